// File: rtl/ps2_tx_fifo.sv
// ps2_tx_fifo
// Device-side PS/2 transmitter fed by a byte FIFO. Bytes written through the
// in_valid/in_ready handshake are queued, then sent one frame at a time:
// start(0), eight data bits LSB first, odd parity, stop(1). The system clock is
// divided down to the PS/2 clock (CLK_DIV clk cycles per half period). If the
// host pulls the clock line low during a frame, the frame is abandoned and the
// same byte is sent again once the host releases the line.
//
// Ports
//   clk, reset     : system clock; synchronous active-high reset
//   in_data        : byte to enqueue
//   in_valid       : enqueue request (accepted when in_ready)
//   in_ready       : FIFO has room (registered level below depth)
//   clr_overflow   : clears the sticky overflow flag
//   ps2_clk_in     : sensed PS/2 clock line, asynchronous
//   ps2_clk        : driven PS/2 clock, 1 = released
//   ps2_data       : driven PS/2 data, 1 = released
//   busy           : frame, inter-frame gap or inhibit wait in progress
//   fifo_level     : bytes stored, 0..2^FIFO_BITS
//   overflow       : sticky, a byte was offered while the FIFO was full
module ps2_tx_fifo #(
    parameter int FIFO_BITS  = 3,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 clr_overflow,
    input  logic                 ps2_clk_in,
    output logic                 ps2_clk,
    output logic                 ps2_data,
    output logic                 busy,
    output logic [FIFO_BITS:0]   fifo_level,
    output logic                 overflow
);

    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [FIFO_BITS:0]   FULL_LEVEL = (FIFO_BITS + 1)'(DEPTH);
    localparam logic [FIFO_BITS:0]   LEVEL_ZERO = (FIFO_BITS + 1)'(0);
    localparam logic [FIFO_BITS:0]   LEVEL_ONE  = (FIFO_BITS + 1)'(1);
    localparam logic [FIFO_BITS-1:0] PTR_ONE    = FIFO_BITS'(1);
    localparam logic [CNT_W-1:0]     CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]     HIGH_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]     LOW_FIRST  = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0]     LOW_LAST   = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [GAP_W-1:0]     GAP_LOAD   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0]     GAP_ZERO   = GAP_W'(0);
    localparam logic [GAP_W-1:0]     GAP_ONE    = GAP_W'(1);
    localparam logic [3:0]           BIT_STOP   = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BIT     = 2'd1,
        ST_GAP     = 2'd2,
        ST_INHIBIT = 2'd3
    } state_t;

    // Odd parity bit: 1 when the byte holds an even number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        odd_parity = ~(^b);
    endfunction

    // Line level for frame position idx of byte b.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic [2:0] pos;
        pos = idx[2:0] - 3'd1;  // idx 1..8 -> data bit 0..7 (idx 8 wraps to 7)
        case (idx)
            4'd0:                                          frame_bit = 1'b0;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: frame_bit = b[pos];
            4'd9:                                          frame_bit = odd_parity(b);
            default:                                       frame_bit = 1'b1;
        endcase
    endfunction

    state_t               state_q, state_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [FIFO_BITS-1:0] wptr_q, wptr_d;
    logic [FIFO_BITS-1:0] rptr_q, rptr_d;
    logic [FIFO_BITS:0]   level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 ps2_clk_q, ps2_clk_d;
    logic                 ps2_data_q, ps2_data_d;
    logic                 busy_q, busy_d;
    logic [7:0]           mem_q [DEPTH];

    logic push_s;
    logic pop_s;
    logic ovf_s;
    logic inh_s;

    assign in_ready   = (level_q != FULL_LEVEL);
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign ps2_clk    = ps2_clk_q;
    assign ps2_data   = ps2_data_q;
    assign busy       = busy_q;
    assign inh_s      = ~sync2_q;

    // Two-stage synchroniser for the sensed clock line.
    always_comb begin
        sync1_d = ps2_clk_in;
        sync2_d = sync1_q;
    end

    // FIFO bookkeeping: pointers, level and the sticky overflow flag.
    always_comb begin
        push_s = in_valid && (level_q != FULL_LEVEL);
        ovf_s  = in_valid && (level_q == FULL_LEVEL);

        if (push_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end

        if (pop_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear keeps the flag set.
        if (ovf_s) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Next-state logic of the frame sequencer.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        gap_cnt_d = gap_cnt_q;
        shift_d   = shift_q;
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Head byte is copied, not popped: an abort must resend it.
                if ((level_q != LEVEL_ZERO) && !inh_s) begin
                    state_d   = ST_BIT;
                    bit_idx_d = 4'd0;
                    cnt_d     = CNT_ZERO;
                    shift_d   = mem_q[rptr_q];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BIT: begin
                // Inhibit is honoured at the end of each high phase except the stop bit.
                if ((cnt_q == HIGH_LAST) && inh_s && (bit_idx_q != BIT_STOP)) begin
                    state_d = ST_INHIBIT;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == LOW_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (bit_idx_q == BIT_STOP) begin
                        pop_s     = 1'b1;
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_ZERO) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
            ST_INHIBIT: begin
                if (!inh_s) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = ST_INHIBIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line and busy levels decoded from the next state, so they are registered
    // and change on the same edge as the sequencer.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        if (state_d == ST_BIT) begin
            ps2_clk_d  = (cnt_d < LOW_FIRST);
            ps2_data_d = frame_bit(shift_d, bit_idx_d);
        end else begin
            ps2_clk_d  = 1'b1;
            ps2_data_d = 1'b1;
        end
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= 4'd0;
            cnt_q      <= CNT_ZERO;
            gap_cnt_q  <= GAP_ZERO;
            shift_q    <= 8'h00;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= LEVEL_ZERO;
            overflow_q <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            cnt_q      <= cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            shift_q    <= shift_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
            busy_q     <= busy_d;
        end
    end

    // FIFO storage; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_q[wptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_ps2_tx_fifo.sv
module tb_ps2_tx_fifo;

    localparam int FIFO_BITS  = 3;
    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 16;
    localparam int DEPTH      = 1 << FIFO_BITS;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [7:0]           in_data = 8'h00;
    logic                 in_valid = 1'b0;
    logic                 clr_overflow = 1'b0;
    logic                 ps2_clk_in = 1'b1;
    logic                 in_ready;
    logic                 ps2_clk;
    logic                 ps2_data;
    logic                 busy;
    logic [FIFO_BITS:0]   fifo_level;
    logic                 overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ps2_tx_fifo #(
        .FIFO_BITS  (FIFO_BITS),
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .clr_overflow (clr_overflow),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an ordered byte queue plus a sticky flag, and a host
    // that decodes frames from the lines the way a PS/2 host would.
    // ------------------------------------------------------------------
    logic [7:0]  model_q[$];
    logic        model_ovf = 1'b0;
    logic        s_reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_clr = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        prev_clk = 1'b1;
    logic        prev_data = 1'b1;
    int          dec_n = 0;
    logic [10:0] dec_bits = 11'h0;
    logic        dec_done = 1'b0;
    int          hi_cnt = 0;
    int          idle_cnt = 0;
    int          last_idle = 0;
    int          since_fall = 0;
    logic        seen_frame = 1'b0;
    int          frames_done = 0;
    int          total_falls = 0;
    int          aborts = 0;
    logic [10:0] last_bits = 11'h0;
    logic [7:0]  last_byte = 8'h00;

    always @(negedge clk) begin
        logic accept;
        // Apply the inputs seen by the posedge that just happened.
        if (s_reset) begin
            model_q.delete();
            model_ovf  = 1'b0;
            dec_n      = 0;
            dec_done   = 1'b0;
            seen_frame = 1'b0;
        end else begin
            accept = s_valid && (model_q.size() < DEPTH);
            if (s_valid && !accept) model_ovf = 1'b1;
            else if (s_clr) model_ovf = 1'b0;
            // The byte leaves the queue when the clock rises after the stop bit.
            if (dec_done && ps2_clk) begin
                if (model_q.size() > 0) void'(model_q.pop_front());
                dec_done = 1'b0;
                dec_n    = 0;
            end
            if (accept) model_q.push_back(s_data);
        end

        since_fall++;
        if (!s_reset && prev_data && !ps2_data && ps2_clk && dec_n == 0) last_idle = idle_cnt;
        if (!s_reset && prev_clk && !ps2_clk) begin
            total_falls++;
            check_value("fall_in_frame", (dec_n < 11), 1'b1);
            if (dec_n < 11) begin
                if (dec_n == 0) begin
                    if (seen_frame) check_value("gap_idle", (last_idle >= GAP_CYCLES), 1'b1);
                end else begin
                    check_value("bit_period", since_fall, 2 * CLK_DIV);
                end
                dec_bits[dec_n] = ps2_data;
                dec_n++;
                if (dec_n == 11) begin
                    last_bits = dec_bits;
                    last_byte = dec_bits[8:1];
                    check_value("start_bit", dec_bits[0], 1'b0);
                    check_value("stop_bit", dec_bits[10], 1'b1);
                    check_value("parity_bit", dec_bits[9], ($countones(dec_bits[8:1]) % 2 == 0));
                    if (model_q.size() == 0) check_value("frame_unexpected", model_q.size(), 1);
                    else check_value("frame_byte", dec_bits[8:1], model_q[0]);
                    dec_done   = 1'b1;
                    seen_frame = 1'b1;
                    frames_done++;
                end
            end
            since_fall = 0;
        end
        if (ps2_clk) hi_cnt++;
        else hi_cnt = 0;
        // A clock held high mid-frame means the device gave the frame up.
        if (dec_n > 0 && dec_n < 11 && hi_cnt > CLK_DIV + 1) begin
            dec_n = 0;
            aborts++;
        end
        if (ps2_clk && ps2_data) idle_cnt++;
        else idle_cnt = 0;

        check_value("fifo_level", fifo_level, model_q.size());
        check_value("in_ready", in_ready, (model_q.size() < DEPTH));
        check_value("overflow", overflow, model_ovf);

        prev_clk  = ps2_clk;
        prev_data = ps2_data;
        s_reset   = reset;
        s_valid   = in_valid;
        s_clr     = clr_overflow;
        s_data    = in_data;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 4000 && frames_done < target; i++) tick();
        check_value("frames_reached", (frames_done >= target), 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 6000 && !(busy == 1'b0 && fifo_level == 0); i++) tick();
        check_value("idle_busy", busy, 1'b0);
        check_value("idle_level", fifo_level, 0);
    endtask

    // Returns on the nfalls-th falling clock edge, or (rising=1) on the rise after it.
    task automatic wait_edge(input int nfalls, input logic rising);
        int   f;
        logic p;
        logic ok;
        f  = 0;
        p  = ps2_clk;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick();
            if (p && !ps2_clk) f++;
            if (!rising && p && !ps2_clk && f == nfalls) ok = 1'b1;
            if (rising && !p && ps2_clk && f == nfalls) ok = 1'b1;
            p = ps2_clk;
        end
        check_value("edge_found", ok, 1'b1);
    endtask

    int n_busy;
    int n_frame;
    int falls;
    int target;
    int falls_before;
    int inh_left;
    logic pclk;

    initial begin
        // Reset values
        reset = 1'b1;
        repeat (3) tick();
        check_value("rst_ps2_clk", ps2_clk, 1'b1);
        check_value("rst_ps2_data", ps2_data, 1'b1);
        check_value("rst_busy", busy, 1'b0);
        check_value("rst_level", fifo_level, 0);
        check_value("rst_overflow", overflow, 1'b0);
        check_value("rst_in_ready", in_ready, 1'b1);
        reset = 1'b0;
        repeat (20) tick();

        // Basic frame 0x1C: 88 cycles of frame, then 16 of gap
        push_byte(8'h1C);
        n_busy  = 0;
        n_frame = 0;
        falls   = 0;
        pclk    = ps2_clk;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (pclk && !ps2_clk) falls++;
            pclk = ps2_clk;
            if (busy) begin
                n_busy++;
                if (!(falls == 11 && ps2_clk)) n_frame++;
            end else if (n_busy > 0) begin
                break;
            end
        end
        check_value("frame_len", n_frame, 88);
        check_value("gap_busy", n_busy - n_frame, GAP_CYCLES);
        check_value("bits_1c", last_bits, 11'b100_0011_1000);
        check_value("level_after_1c", fifo_level, 0);

        // Parity of 0x00 and 0xFF
        target = frames_done + 1;
        push_byte(8'h00);
        push_byte(8'hFF);
        wait_frames(target);
        check_value("par_00", last_bits[9], 1'b1);
        wait_frames(target + 1);
        check_value("par_ff", last_bits[9], 1'b1);
        check_value("byte_ff", last_byte, 8'hFF);
        wait_idle();

        // Fill while the host inhibits, overflow on the ninth byte
        ps2_clk_in = 1'b0;
        repeat (4) tick();
        for (int b = 1; b <= 9; b++) push_byte(8'(b));
        check_value("full_level", fifo_level, DEPTH);
        check_value("full_ready", in_ready, 1'b0);
        check_value("full_ovf", overflow, 1'b1);
        repeat (10) tick();
        check_value("inhibit_no_start", busy, 1'b0);
        ps2_clk_in = 1'b1;
        target = frames_done + 8;
        wait_frames(target);
        check_value("last_of_eight", last_byte, 8'h08);
        wait_idle();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check_value("ovf_cleared", overflow, 1'b0);

        // Inhibit during the BIT4 high phase aborts and resends 0xA5
        repeat (20) tick();
        push_byte(8'hA5);
        wait_edge(4, 1'b1);
        ps2_clk_in = 1'b0;
        repeat (3) tick();
        check_value("abort_pre_data", ps2_data, 1'b0);
        tick();
        check_value("abort_clk_high", ps2_clk, 1'b1);
        check_value("abort_data_high", ps2_data, 1'b1);
        falls_before = total_falls;
        repeat (196) tick();
        check_value("abort_quiet", total_falls, falls_before);
        check_value("abort_level", fifo_level, 1);
        check_value("abort_busy", busy, 1'b1);
        target = frames_done + 1;
        ps2_clk_in = 1'b1;
        wait_frames(target);
        check_value("resent_byte", last_byte, 8'hA5);
        wait_idle();

        // Push offered in the pop cycle while full is refused
        ps2_clk_in = 1'b0;
        repeat (4) tick();
        for (int b = 0; b < DEPTH; b++) push_byte(8'($urandom));
        check_value("fill_level", fifo_level, DEPTH);
        check_value("fill_ovf", overflow, 1'b0);
        ps2_clk_in = 1'b1;
        wait_edge(11, 1'b0);
        repeat (3) tick();
        in_data  = 8'h55;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_value("pop_cycle_clk", ps2_clk, 1'b1);
        check_value("pop_cycle_ovf", overflow, 1'b1);
        check_value("pop_cycle_level", fifo_level, DEPTH - 1);
        wait_idle();

        // Reset during BIT6 (overflow is still set from above)
        repeat (20) tick();
        push_byte(8'h3C);
        push_byte(8'h81);
        wait_edge(6, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_value("mid_rst_clk", ps2_clk, 1'b1);
        check_value("mid_rst_data", ps2_data, 1'b1);
        check_value("mid_rst_level", fifo_level, 0);
        check_value("mid_rst_busy", busy, 1'b0);
        check_value("mid_rst_ovf", overflow, 1'b0);
        falls_before = total_falls;
        repeat (300) tick();
        check_value("mid_rst_no_frames", total_falls, falls_before);

        // Randomised traffic with short host inhibit pulses
        inh_left = 0;
        for (int c = 0; c < 3000; c++) begin
            in_valid     = ($urandom_range(39) == 0);
            in_data      = 8'($urandom);
            clr_overflow = ($urandom_range(99) == 0);
            if (inh_left > 0) begin
                inh_left--;
                ps2_clk_in = 1'b0;
            end else begin
                ps2_clk_in = 1'b1;
                if ($urandom_range(199) == 0) inh_left = int'($urandom_range(40, 1));
            end
            tick();
        end
        in_valid     = 1'b0;
        clr_overflow = 1'b0;
        ps2_clk_in   = 1'b1;
        wait_idle();
        check_value("model_drained", model_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
